// File: rtl/input_controller_if.sv
// ----------------------------------------------------------------------------
// input_controller_if
// Bundles the FIFO-side, allocator-side and crossbar-side signals of one
// NoC router input port controller.
//   Data_in  [7:0] : FIFO head (first-word-fall-through), valid when !empty
//   empty          : FIFO empty flag
//   grant          : switch-allocator grant for the pending request
//   Data_out [7:0] : flit driven toward the crossbar
//   read           : one-cycle FIFO pop pulse
//   register [2:0] : requested output port (111 = no request)
// Modports:
//   master : the controller itself (drives Data_out/read/register)
//   slave  : the surrounding FIFO/allocator/crossbar (drives Data_in/empty/grant)
// ----------------------------------------------------------------------------
interface input_controller_if;
    logic [7:0] Data_in;
    logic       empty;
    logic       grant;
    logic [7:0] Data_out;
    logic       read;
    logic [2:0] register;

    modport master (
        input  Data_in,
        input  empty,
        input  grant,
        output Data_out,
        output read,
        output register
    );

    modport slave (
        output Data_in,
        output empty,
        output grant,
        input  Data_out,
        input  read,
        input  register
    );
endinterface

// File: rtl/input_controller.sv
// ----------------------------------------------------------------------------
// input_controller
// Per-input-port controller of a 4x4 mesh NoC router. Pops one 8-bit flit
// at a time from the input FIFO, computes its output port with XY
// dimension-ordered routing, requests that port from the switch allocator
// and, once granted, presents the flit to the crossbar for one cycle.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   X_cur    : this router's X coordinate (static)
//   Y_cur    : this router's Y coordinate (static)
//   bus      : input_controller_if.master (FIFO, allocator, crossbar signals)
// Flit layout: [1:0] x_des, [3:2] y_des, [7:4] payload.
// Port code:  000 Local, 001 East, 010 West, 011 North, 100 South, 111 none.
// ----------------------------------------------------------------------------
module input_controller (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                X_cur,
    input  logic [1:0]                Y_cur,
    input_controller_if.master        bus
);

    localparam logic [2:0] PORT_LOCAL = 3'b000;
    localparam logic [2:0] PORT_EAST  = 3'b001;
    localparam logic [2:0] PORT_WEST  = 3'b010;
    localparam logic [2:0] PORT_NORTH = 3'b011;
    localparam logic [2:0] PORT_SOUTH = 3'b100;
    localparam logic [2:0] PORT_NONE  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_SEND = 2'b10
    } state_t;

    // XY routing: X is resolved first, Y only when X already matches.
    function automatic logic [2:0] xy_route(
        input logic [1:0] x_des,
        input logic [1:0] y_des,
        input logic [1:0] x_cur,
        input logic [1:0] y_cur
    );
        logic [2:0] port;
        if (x_des > x_cur) begin
            port = PORT_EAST;
        end else if (x_des < x_cur) begin
            port = PORT_WEST;
        end else if (y_des > y_cur) begin
            port = PORT_NORTH;
        end else if (y_des < y_cur) begin
            port = PORT_SOUTH;
        end else begin
            port = PORT_LOCAL;
        end
        return port;
    endfunction

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_flit;
    logic [7:0] w_flit_nxt;
    logic [7:0] r_data_out;
    logic [7:0] w_data_out_nxt;
    logic [2:0] r_register;
    logic [2:0] w_register_nxt;
    logic       r_read;
    logic       w_read_nxt;
    logic [2:0] w_route;

    // Route of the current FIFO head; only used at the pop edge.
    always_comb begin
        w_route = xy_route(bus.Data_in[1:0], bus.Data_in[3:2], X_cur, Y_cur);
    end

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        w_state_nxt    = r_state;
        w_flit_nxt     = r_flit;
        w_data_out_nxt = r_data_out;
        w_register_nxt = r_register;
        w_read_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // grant is irrelevant here; only a non-empty FIFO starts a flit
                if (!bus.empty) begin
                    w_flit_nxt     = bus.Data_in;
                    w_register_nxt = w_route;
                    w_read_nxt     = 1'b1;
                    w_state_nxt    = ST_REQ;
                end else begin
                    w_register_nxt = PORT_NONE;
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Request stays up until granted; the FIFO head is ignored
                // because the flit has already been popped and latched.
                if (bus.grant) begin
                    w_data_out_nxt = r_flit;
                    w_state_nxt    = ST_SEND;
                end else begin
                    w_state_nxt    = ST_REQ;
                end
            end
            ST_SEND: begin
                // Single transfer cycle; register kept stable until now so
                // the crossbar select does not move under the flit.
                w_register_nxt = PORT_NONE;
                w_state_nxt    = ST_IDLE;
            end
            default: begin
                w_register_nxt = PORT_NONE;
                w_state_nxt    = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_flit     <= 8'h00;
            r_data_out <= 8'h00;
            r_register <= PORT_NONE;
            r_read     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_flit     <= w_flit_nxt;
            r_data_out <= w_data_out_nxt;
            r_register <= w_register_nxt;
            r_read     <= w_read_nxt;
        end
    end

    assign bus.Data_out = r_data_out;
    assign bus.read     = r_read;
    assign bus.register = r_register;

endmodule

// File: tb/tb_input_controller.sv
module tb_input_controller;

    logic       clk;
    logic       rst;
    logic [1:0] X_cur;
    logic [1:0] Y_cur;

    input_controller_if bus ();

    input_controller dut (
        .clk   (clk),
        .rst   (rst),
        .X_cur (X_cur),
        .Y_cur (Y_cur),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference routing from the coordinate rules using signed differences.
    function automatic logic [2:0] ref_route(input logic [7:0] f,
                                             input logic [1:0] xc,
                                             input logic [1:0] yc);
        int dx;
        int dy;
        dx = int'(f[1:0]) - int'(xc);
        dy = int'(f[3:2]) - int'(yc);
        if (dx > 0)      return 3'd1;
        else if (dx < 0) return 3'd2;
        else if (dy > 0) return 3'd3;
        else if (dy < 0) return 3'd4;
        else             return 3'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full flit transaction from IDLE: pop, wait for grant, send, return.
    task automatic run_flit(input logic [7:0] f, input int gdelay, input string tag);
        logic [2:0] exp_r;
        exp_r = ref_route(f, X_cur, Y_cur);
        bus.Data_in = f;
        bus.empty   = 1'b0;
        bus.grant   = 1'($urandom_range(0, 1));
        tick();
        n_cmp++;
        if (bus.read !== 1'b1 || bus.register !== exp_r) begin
            n_err++;
            $display("FAIL %s_pop: read=%b register=%b, want read=1 register=%b", tag, bus.read, bus.register, exp_r);
        end
        bus.empty   = 1'($urandom_range(0, 1));
        bus.Data_in = 8'($urandom);
        bus.grant   = 1'b0;
        for (int i = 0; i < gdelay; i++) begin
            tick();
            n_cmp++;
            if (bus.read !== 1'b0 || bus.register !== exp_r) begin
                n_err++;
                $display("FAIL %s_req: read=%b register=%b, want read=0 register=%b", tag, bus.read, bus.register, exp_r);
            end
        end
        bus.grant = 1'b1;
        tick();
        n_cmp++;
        if (bus.Data_out !== f || bus.register !== exp_r || bus.read !== 1'b0) begin
            n_err++;
            $display("FAIL %s_send: Data_out=%h register=%b read=%b, want Data_out=%h register=%b read=0",
                     tag, bus.Data_out, bus.register, bus.read, f, exp_r);
        end
        bus.grant = 1'($urandom_range(0, 1));
        bus.empty = 1'($urandom_range(0, 1));
        tick();
        n_cmp++;
        if (bus.register !== 3'b111 || bus.read !== 1'b0 || bus.Data_out !== f) begin
            n_err++;
            $display("FAIL %s_done: register=%b read=%b Data_out=%h, want register=111 read=0 Data_out=%h",
                     tag, bus.register, bus.read, bus.Data_out, f);
        end
        bus.empty = 1'b1;
        bus.grant = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.empty   = 1'b0;
        bus.Data_in = 8'h06;
        bus.grant   = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (bus.register !== 3'b111 || bus.read !== 1'b0 || bus.Data_out !== 8'h00) begin
            n_err++;
            $display("FAIL reset: register=%b read=%b Data_out=%h, want 111/0/00", bus.register, bus.read, bus.Data_out);
        end
        bus.grant = 1'b0;
    endtask

    task automatic test_south();
        X_cur = 2'd2;
        Y_cur = 2'd2;
        bus.Data_in = 8'h06;
        bus.empty   = 1'b0;
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.read !== 1'b1 || bus.register !== 3'b100) begin
            n_err++;
            $display("FAIL south_pop: read=%b register=%b, want 1/100", bus.read, bus.register);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (bus.read !== 1'b0 || bus.register !== 3'b100) begin
                n_err++;
                $display("FAIL south_hold: read=%b register=%b, want 0/100", bus.read, bus.register);
            end
        end
    endtask

    task automatic test_grant_send();
        bus.empty = 1'b1;
        bus.grant = 1'b1;
        tick();
        n_cmp++;
        if (bus.Data_out !== 8'h06 || bus.register !== 3'b100) begin
            n_err++;
            $display("FAIL grant_send: Data_out=%h register=%b, want 06/100", bus.Data_out, bus.register);
        end
        bus.grant = 1'b0;
        tick();
        n_cmp++;
        if (bus.register !== 3'b111) begin
            n_err++;
            $display("FAIL grant_release: register=%b, want 111", bus.register);
        end
    endtask

    task automatic test_routes();
        logic [7:0] flits [4];
        logic [2:0] codes [4];
        flits = '{8'h07, 8'h0E, 8'h05, 8'h0A};
        codes = '{3'b001, 3'b011, 3'b010, 3'b000};
        X_cur = 2'd2;
        Y_cur = 2'd2;
        for (int k = 0; k < 4; k++) begin
            // fixed spec codes cross-check the reference routing function
            n_cmp++;
            if (ref_route(flits[k], X_cur, Y_cur) !== codes[k]) begin
                n_err++;
                $display("FAIL route_ref: flit=%h model=%b, want %b", flits[k], ref_route(flits[k], X_cur, Y_cur), codes[k]);
            end
            run_flit(flits[k], k, "route");
        end
    endtask

    task automatic test_empty();
        bus.empty   = 1'b1;
        bus.Data_in = 8'h0E;
        for (int i = 0; i < 4; i++) begin
            bus.grant = 1'(i);
            tick();
            n_cmp++;
            if (bus.read !== 1'b0 || bus.register !== 3'b111) begin
                n_err++;
                $display("FAIL empty: read=%b register=%b, want 0/111", bus.read, bus.register);
            end
        end
        bus.grant = 1'b0;
    endtask

    task automatic test_reset_mid_req();
        X_cur = 2'd2;
        Y_cur = 2'd2;
        bus.Data_in = 8'h07;
        bus.empty   = 1'b0;
        tick();
        n_cmp++;
        if (bus.register !== 3'b001 || bus.read !== 1'b1) begin
            n_err++;
            $display("FAIL midreq_pop: register=%b read=%b, want 001/1", bus.register, bus.read);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (bus.register !== 3'b111 || bus.read !== 1'b0) begin
            n_err++;
            $display("FAIL midreq_rst: register=%b read=%b, want 111/0", bus.register, bus.read);
        end
        rst = 1'b0;
        bus.empty = 1'b1;
        bus.grant = 1'b1;
        tick();
        n_cmp++;
        if (bus.register !== 3'b111 || bus.Data_out !== 8'h00) begin
            n_err++;
            $display("FAIL midreq_idle: register=%b Data_out=%h, want 111/00", bus.register, bus.Data_out);
        end
        // reset during SEND clears Data_out
        bus.grant   = 1'b0;
        bus.Data_in = 8'h5A;
        bus.empty   = 1'b0;
        tick();
        bus.empty = 1'b1;
        bus.grant = 1'b1;
        tick();
        n_cmp++;
        if (bus.Data_out !== 8'h5A) begin
            n_err++;
            $display("FAIL midsend_out: Data_out=%h, want 5a", bus.Data_out);
        end
        bus.grant = 1'b0;
        rst = 1'b1;
        tick();
        n_cmp++;
        if (bus.Data_out !== 8'h00 || bus.register !== 3'b111) begin
            n_err++;
            $display("FAIL midsend_rst: Data_out=%h register=%b, want 00/111", bus.Data_out, bus.register);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            X_cur = 2'($urandom);
            Y_cur = 2'($urandom);
            run_flit(8'($urandom), int'($urandom_range(0, 3)), "rand");
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q [$];
        logic [2:0] exp_r;
        for (int k = 0; k < 9; k++) q.push_back(8'($urandom));
        X_cur = 2'd1;
        Y_cur = 2'd2;
        bus.Data_in = q[0];
        bus.empty   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_r = ref_route(q[k], X_cur, Y_cur);
            tick();
            n_cmp++;
            if (bus.read !== 1'b1 || bus.register !== exp_r) begin
                n_err++;
                $display("FAIL b2b_pop: read=%b register=%b, want 1/%b", bus.read, bus.register, exp_r);
            end
            bus.Data_in = q[k+1];
            bus.grant   = 1'b1;
            tick();
            n_cmp++;
            if (bus.read !== 1'b0 || bus.Data_out !== q[k]) begin
                n_err++;
                $display("FAIL b2b_send: read=%b Data_out=%h, want 0/%h", bus.read, bus.Data_out, q[k]);
            end
            bus.grant = 1'b0;
            tick();
            n_cmp++;
            if (bus.read !== 1'b0 || bus.register !== 3'b111) begin
                n_err++;
                $display("FAIL b2b_idle: read=%b register=%b, want 0/111", bus.read, bus.register);
            end
        end
        bus.empty = 1'b1;
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        X_cur       = 2'd0;
        Y_cur       = 2'd0;
        bus.Data_in = 8'h00;
        bus.empty   = 1'b1;
        bus.grant   = 1'b0;
        test_reset();
        test_south();
        test_grant_send();
        test_routes();
        test_empty();
        test_reset_mid_req();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
